rggen_register_bus_adapter: RTL and testbench

//  Bridge between a host bus port and the per-register decoders in a register block.

---
 rtl/rggen_register_bus_adapter.sv | 200 ++++++++++++++++++++
 tb/tb_rggen_register_bus_adapter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_register_bus_adapter.sv
// Host-bus to register-block adapter: registers one host request, broadcasts it to
// every register slot and returns one registered response built from the hitting slot.
module rggen_register_bus_adapter #(
    parameter int                       ADDRESS_WIDTH       = 8,
    parameter int                       LOCAL_ADDRESS_WIDTH = 8,
    parameter int                       BUS_WIDTH           = 32,
    parameter int                       REGISTERS           = 1,
    parameter bit                       PRE_DECODE          = 1'b0,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
    parameter int                       BYTE_SIZE           = 256,
    parameter bit                       ERROR_STATUS        = 1'b0,
    parameter logic [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_bus_valid,
    input  logic                           i_bus_write,
    input  logic [ADDRESS_WIDTH-1:0]       i_bus_address,
    input  logic [BUS_WIDTH-1:0]           i_bus_write_data,
    input  logic [BUS_WIDTH/8-1:0]         i_bus_strobe,
    output logic                           o_bus_ready,
    output logic [1:0]                     o_bus_status,
    output logic [BUS_WIDTH-1:0]           o_bus_read_data,
    output logic                           o_reg_valid,
    output logic                           o_reg_write,
    output logic [LOCAL_ADDRESS_WIDTH-1:0] o_reg_address,
    output logic [BUS_WIDTH-1:0]           o_reg_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_reg_strobe,
    input  logic [REGISTERS-1:0]           i_reg_active,
    input  logic [REGISTERS-1:0]           i_reg_ready,
    input  logic [2*REGISTERS-1:0]         i_reg_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_read_data
);

    localparam int STROBE_WIDTH = BUS_WIDTH / 8;
    localparam int WORD_LSB     = (STROBE_WIDTH > 1) ? $clog2(STROBE_WIDTH) : 0;

    localparam logic [LOCAL_ADDRESS_WIDTH-1:0] ALIGN_MASK  = {LOCAL_ADDRESS_WIDTH{1'b1}} << WORD_LSB;
    localparam logic [ADDRESS_WIDTH:0]         WINDOW_BASE = {1'b0, BASE_ADDRESS};
    localparam logic [ADDRESS_WIDTH:0]         WINDOW_SIZE = (ADDRESS_WIDTH + 1)'(BYTE_SIZE);

    localparam logic [1:0] STATUS_OKAY   = 2'b00;
    localparam logic [1:0] STATUS_SLVERR = 2'b10;
    localparam logic [1:0] STATUS_DECERR = 2'b11;
    localparam logic [1:0] NOHIT_STATUS  = ERROR_STATUS ? STATUS_SLVERR : STATUS_OKAY;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        RESPOND = 2'b10
    } state_e;

    state_e                           r_state;
    logic                             r_in_window;
    logic                             r_reg_valid;
    logic                             r_reg_write;
    logic [LOCAL_ADDRESS_WIDTH-1:0]   r_reg_address;
    logic [BUS_WIDTH-1:0]             r_reg_write_data;
    logic [STROBE_WIDTH-1:0]          r_reg_strobe;
    logic                             r_bus_ready;
    logic [1:0]                       r_bus_status;
    logic [BUS_WIDTH-1:0]             r_bus_read_data;

    logic [ADDRESS_WIDTH:0]           w_window_offset;
    logic                             w_in_window;
    logic [LOCAL_ADDRESS_WIDTH-1:0]   w_local_address;
    logic                             w_hit;
    logic                             w_ready;
    logic [1:0]                       w_status;
    logic [BUS_WIDTH-1:0]             w_read_data;

    // Window check on the incoming address; an address below the base wraps to a large
    // offset in ADDRESS_WIDTH+1 bits, so a single compare covers both window edges.
    always_comb begin
        w_window_offset = {1'b0, i_bus_address} - WINDOW_BASE;
        w_in_window     = (PRE_DECODE == 1'b0) || (w_window_offset < WINDOW_SIZE);
        w_local_address = i_bus_address[LOCAL_ADDRESS_WIDTH-1:0] & ALIGN_MASK;
    end

    // Merge the slot responses; active is one-hot or zero, so masking and OR selects the hitter.
    always_comb begin
        w_hit       = |i_reg_active;
        w_ready     = 1'b0;
        w_status    = 2'b00;
        w_read_data = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            w_ready     = w_ready | (i_reg_active[k] & i_reg_ready[k]);
            w_status    = w_status | (i_reg_status[2*k+:2] & {2{i_reg_active[k]}});
            w_read_data = w_read_data
                        | (i_reg_read_data[BUS_WIDTH*k+:BUS_WIDTH] & {BUS_WIDTH{i_reg_active[k]}});
        end
    end

    // Access FSM; owns every registered output on both the host and the register side.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= IDLE;
            r_in_window      <= 1'b0;
            r_reg_valid      <= 1'b0;
            r_reg_write      <= 1'b0;
            r_reg_address    <= '0;
            r_reg_write_data <= '0;
            r_reg_strobe     <= '0;
            r_bus_ready      <= 1'b0;
            r_bus_status     <= 2'b00;
            r_bus_read_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_bus_valid) begin
                        r_state          <= BUSY;
                        r_in_window      <= w_in_window;
                        r_reg_valid      <= w_in_window;
                        r_reg_write      <= i_bus_write;
                        r_reg_address    <= w_local_address;
                        r_reg_write_data <= i_bus_write_data;
                        r_reg_strobe     <= i_bus_write ? i_bus_strobe : {STROBE_WIDTH{1'b0}};
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (!r_in_window) begin
                        r_state         <= RESPOND;
                        r_bus_ready     <= 1'b1;
                        r_bus_status    <= STATUS_DECERR;
                        r_bus_read_data <= r_reg_write ? {BUS_WIDTH{1'b0}} : DEFAULT_READ_DATA;
                    end else if (!w_hit) begin
                        r_state         <= RESPOND;
                        r_reg_valid     <= 1'b0;
                        r_bus_ready     <= 1'b1;
                        r_bus_status    <= NOHIT_STATUS;
                        r_bus_read_data <= r_reg_write ? {BUS_WIDTH{1'b0}} : DEFAULT_READ_DATA;
                    end else if (w_ready) begin
                        r_state         <= RESPOND;
                        r_reg_valid     <= 1'b0;
                        r_bus_ready     <= 1'b1;
                        r_bus_status    <= w_status;
                        r_bus_read_data <= r_reg_write ? {BUS_WIDTH{1'b0}} : w_read_data;
                    end else begin
                        // Selected register is stalling: keep the broadcast steady.
                        r_state <= BUSY;
                    end
                end
                RESPOND: begin
                    r_state         <= IDLE;
                    r_bus_ready     <= 1'b0;
                    r_bus_status    <= 2'b00;
                    r_bus_read_data <= '0;
                end
                default: begin
                    r_state         <= IDLE;
                    r_reg_valid     <= 1'b0;
                    r_bus_ready     <= 1'b0;
                    r_bus_status    <= 2'b00;
                    r_bus_read_data <= '0;
                end
            endcase
        end
    end

    assign o_bus_ready      = r_bus_ready;
    assign o_bus_status     = r_bus_status;
    assign o_bus_read_data  = r_bus_read_data;
    assign o_reg_valid      = r_reg_valid;
    assign o_reg_write      = r_reg_write;
    assign o_reg_address    = r_reg_address;
    assign o_reg_write_data = r_reg_write_data;
    assign o_reg_strobe     = r_reg_strobe;

`ifdef RGGEN_ENABLE_SVA
    rggen_register_bus_adapter_checker #(
        .REGISTERS (REGISTERS)
    ) u_checker (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_reg_valid  (r_reg_valid),
        .i_reg_active (i_reg_active)
    );
`endif

endmodule

`ifdef RGGEN_ENABLE_SVA
// Protocol checker: at most one register may claim a broadcast access.
module rggen_register_bus_adapter_checker #(
    parameter int REGISTERS = 1
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    input logic                 i_reg_valid,
    input logic [REGISTERS-1:0] i_reg_active
);

    a_active_onehot0 : assert property (
        @(posedge i_clk) disable iff (!i_rst_n) i_reg_valid |-> $onehot0(i_reg_active)
    );

endmodule
`endif

// File: tb/tb_rggen_register_bus_adapter.sv
// Self-checking bench for rggen_register_bus_adapter: a 4-slot register model in the
// window 0x40..0x4F, and a queue of expected host responses popped on each o_bus_ready.
module tb_rggen_register_bus_adapter;

    typedef struct packed {
        logic [1:0]  status;
        logic [31:0] data;
    } resp_t;

    logic         clk;
    logic         rst_n;
    logic         bus_valid;
    logic         bus_write;
    logic [7:0]   bus_address;
    logic [31:0]  bus_write_data;
    logic [3:0]   bus_strobe;
    logic         o_bus_ready;
    logic [1:0]   o_bus_status;
    logic [31:0]  o_bus_read_data;
    logic         o_reg_valid;
    logic         o_reg_write;
    logic [7:0]   o_reg_address;
    logic [31:0]  o_reg_write_data;
    logic [3:0]   o_reg_strobe;
    logic [3:0]   reg_active;
    logic [3:0]   reg_ready;
    logic [7:0]   reg_status;
    logic [127:0] reg_read_data;

    logic [3:0]   tb_present;
    logic [1:0]   tb_status [4];
    int           tb_wait;
    int           wait_cnt;

    resp_t        exp_q [$];
    int           checks;
    int           errors;

    int           obs_latency;
    int           obs_reg_valid_cycles;
    bit           obs_changed;
    logic         obs_write;
    logic [7:0]   obs_addr;
    logic [31:0]  obs_wdata;
    logic [3:0]   obs_strb;

    logic [80:0]  all_out;
    assign all_out = {o_bus_ready, o_bus_status, o_bus_read_data, o_reg_valid, o_reg_write,
                      o_reg_address, o_reg_write_data, o_reg_strobe};

    rggen_register_bus_adapter #(
        .ADDRESS_WIDTH       (8),
        .LOCAL_ADDRESS_WIDTH (8),
        .BUS_WIDTH           (32),
        .REGISTERS           (4),
        .PRE_DECODE          (1'b1),
        .BASE_ADDRESS        (8'h40),
        .BYTE_SIZE           (16),
        .ERROR_STATUS        (1'b1),
        .DEFAULT_READ_DATA   (32'hDEAD_BEEF)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_bus_valid      (bus_valid),
        .i_bus_write      (bus_write),
        .i_bus_address    (bus_address),
        .i_bus_write_data (bus_write_data),
        .i_bus_strobe     (bus_strobe),
        .o_bus_ready      (o_bus_ready),
        .o_bus_status     (o_bus_status),
        .o_bus_read_data  (o_bus_read_data),
        .o_reg_valid      (o_reg_valid),
        .o_reg_write      (o_reg_write),
        .o_reg_address    (o_reg_address),
        .o_reg_write_data (o_reg_write_data),
        .o_reg_strobe     (o_reg_strobe),
        .i_reg_active     (reg_active),
        .i_reg_ready      (reg_ready),
        .i_reg_status     (reg_status),
        .i_reg_read_data  (reg_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles the current broadcast has been visible; drives the register wait states.
    always_ff @(posedge clk) begin
        if (!o_reg_valid) wait_cnt <= 0;
        else              wait_cnt <= wait_cnt + 1;
    end

    // Register model: slot k decodes 0x40+4k; inactive slots show ready, status and data
    // anyway so that the adapter's masking is exercised.
    always_comb begin
        reg_active    = 4'b0000;
        reg_ready     = 4'b0000;
        reg_status    = 8'h00;
        reg_read_data = '0;
        for (int k = 0; k < 4; k++) begin
            reg_active[k] = o_reg_valid && tb_present[k] && (o_reg_address == (8'h40 + 8'(4 * k)));
            reg_ready[k]  = tb_present[k] && (!reg_active[k] || (wait_cnt >= tb_wait));
            reg_status[2*k+:2]      = tb_status[k];
            reg_read_data[32*k+:32] = {16'hCAFE, 16'(k)};
        end
    end

    task automatic run_access(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [1:0] exp_status,
                              input logic [31:0] exp_data, input bit chain, input bit hold,
                              input string name);
        resp_t exp_r;
        resp_t got_r;
        bit    done;
        exp_r.status = exp_status;
        exp_r.data   = exp_data;
        exp_q.push_back(exp_r);
        if (!chain) @(negedge clk);
        bus_valid      = 1'b1;
        bus_write      = wr;
        bus_address    = addr;
        bus_write_data = wdata;
        bus_strobe     = strb;
        obs_latency          = 0;
        obs_reg_valid_cycles = 0;
        obs_changed          = 1'b0;
        done                 = 1'b0;
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            @(negedge clk);
            if (o_reg_valid) begin
                if (obs_reg_valid_cycles == 0) begin
                    obs_write = o_reg_write;
                    obs_addr  = o_reg_address;
                    obs_wdata = o_reg_write_data;
                    obs_strb  = o_reg_strobe;
                end else if ({obs_write, obs_addr, obs_wdata, obs_strb} !==
                             {o_reg_write, o_reg_address, o_reg_write_data, o_reg_strobe}) begin
                    obs_changed = 1'b1;
                end
                obs_reg_valid_cycles++;
            end
            if (o_bus_ready) begin
                done        = 1'b1;
                obs_latency = cyc;
                got_r.status = o_bus_status;
                got_r.data   = o_bus_read_data;
                exp_r        = exp_q.pop_front();
                checks++;
                if (got_r !== exp_r) begin
                    errors++;
                    $display("FAIL %s response: status=%b data=%h, expected status=%b data=%h",
                             name, got_r.status, got_r.data, exp_r.status, exp_r.data);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no o_bus_ready within 20 cycles, expected one", name);
            exp_q.delete();
        end
        if (!hold) begin
            bus_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (o_bus_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s single_pulse: o_bus_ready=%b, expected 0", name, o_bus_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (all_out !== 81'd0) begin
            errors++;
            $display("FAIL reset_outputs: outputs=%h, expected 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== 81'd0) begin
            errors++;
            $display("FAIL idle_outputs: outputs=%h, expected 0", all_out);
        end
    endtask

    task automatic test_read_hit();
        tb_wait = 0;
        run_access(1'b0, 8'h48, 32'h1111_2222, 4'hF, 2'b00, 32'hCAFE_0002, 1'b0, 1'b0, "read_hit");
        checks++;
        if (obs_latency !== 2) begin
            errors++;
            $display("FAIL read_hit latency: %0d cycles, expected 2", obs_latency);
        end
        checks++;
        if ({obs_write, obs_addr, obs_strb} !== {1'b0, 8'h48, 4'h0}) begin
            errors++;
            $display("FAIL read_hit reg_fields: write=%b addr=%h strobe=%b, expected 0 48 0000",
                     obs_write, obs_addr, obs_strb);
        end
    endtask

    task automatic test_write_stall();
        tb_wait = 3;
        run_access(1'b1, 8'h40, 32'h1234_5678, 4'b0101, 2'b00, 32'h0, 1'b0, 1'b0, "write_stall");
        checks++;
        if (obs_reg_valid_cycles !== 4 || obs_changed !== 1'b0) begin
            errors++;
            $display("FAIL write_stall hold: valid_cycles=%0d changed=%b, expected 4 0",
                     obs_reg_valid_cycles, obs_changed);
        end
        checks++;
        if ({obs_write, obs_addr, obs_wdata, obs_strb} !== {1'b1, 8'h40, 32'h1234_5678, 4'b0101}) begin
            errors++;
            $display("FAIL write_stall reg_fields: write=%b addr=%h data=%h strobe=%b, expected 1 40 12345678 0101",
                     obs_write, obs_addr, obs_wdata, obs_strb);
        end
        checks++;
        if (obs_latency !== 5) begin
            errors++;
            $display("FAIL write_stall latency: %0d cycles, expected 5", obs_latency);
        end
        tb_wait = 0;
    endtask

    task automatic test_status_select();
        tb_status[1] = 2'b10;
        run_access(1'b0, 8'h44, 32'h0, 4'h0, 2'b10, 32'hCAFE_0001, 1'b0, 1'b0, "status_select");
        tb_status[1] = 2'b00;
    endtask

    task automatic test_no_hit();
        tb_present = 4'b0111;
        run_access(1'b0, 8'h4C, 32'h0, 4'h0, 2'b10, 32'hDEAD_BEEF, 1'b0, 1'b0, "no_hit_read");
        checks++;
        if (obs_reg_valid_cycles !== 1) begin
            errors++;
            $display("FAIL no_hit_read valid_cycles: %0d, expected 1", obs_reg_valid_cycles);
        end
        run_access(1'b1, 8'h4C, 32'hA5A5_A5A5, 4'hF, 2'b10, 32'h0, 1'b0, 1'b0, "no_hit_write");
        tb_present = 4'b1111;
    endtask

    task automatic test_out_of_window();
        run_access(1'b0, 8'h50, 32'h0, 4'h0, 2'b11, 32'hDEAD_BEEF, 1'b0, 1'b0, "decerr_above");
        checks++;
        if (obs_reg_valid_cycles !== 0 || obs_latency !== 2) begin
            errors++;
            $display("FAIL decerr_above: valid_cycles=%0d latency=%0d, expected 0 2",
                     obs_reg_valid_cycles, obs_latency);
        end
        run_access(1'b0, 8'h3C, 32'h0, 4'h0, 2'b11, 32'hDEAD_BEEF, 1'b0, 1'b0, "decerr_below");
        checks++;
        if (obs_reg_valid_cycles !== 0) begin
            errors++;
            $display("FAIL decerr_below valid_cycles: %0d, expected 0", obs_reg_valid_cycles);
        end
    endtask

    task automatic test_address_align();
        run_access(1'b0, 8'h47, 32'h0, 4'h0, 2'b00, 32'hCAFE_0001, 1'b0, 1'b0, "align");
        checks++;
        if (obs_addr !== 8'h44) begin
            errors++;
            $display("FAIL align reg_address: %h, expected 44", obs_addr);
        end
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 8'h40, 32'h0, 4'h0, 2'b00, 32'hCAFE_0000, 1'b0, 1'b1, "b2b_first");
        run_access(1'b0, 8'h4C, 32'h0, 4'h0, 2'b00, 32'hCAFE_0003, 1'b1, 1'b0, "b2b_second");
        checks++;
        if (obs_latency !== 3) begin
            errors++;
            $display("FAIL b2b spacing: %0d cycles between responses, expected 3", obs_latency);
        end
    endtask

    task automatic test_reset_mid_access();
        int pulses;
        tb_wait = 5;
        @(negedge clk);
        bus_valid   = 1'b1;
        bus_write   = 1'b0;
        bus_address = 8'h40;
        @(negedge clk);
        checks++;
        if (o_reg_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset busy: o_reg_valid=%b, expected 1", o_reg_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 81'd0) begin
            errors++;
            $display("FAIL mid_reset outputs: outputs=%h, expected 0", all_out);
        end
        @(negedge clk);
        bus_valid = 1'b0;
        rst_n     = 1'b1;
        pulses    = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_bus_ready || o_reg_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL mid_reset dropped: %0d active cycles after release, expected 0", pulses);
        end
        tb_wait = 0;
        run_access(1'b0, 8'h48, 32'h0, 4'h0, 2'b00, 32'hCAFE_0002, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        bus_valid      = 1'b0;
        bus_write      = 1'b0;
        bus_address    = 8'h00;
        bus_write_data = 32'h0;
        bus_strobe     = 4'h0;
        tb_present     = 4'b1111;
        tb_status[0]   = 2'b00;
        tb_status[1]   = 2'b00;
        tb_status[2]   = 2'b00;
        tb_status[3]   = 2'b00;
        tb_wait        = 0;
        test_reset();
        test_read_hit();
        test_write_stall();
        test_status_select();
        test_no_hit();
        test_out_of_window();
        test_address_align();
        test_back_to_back();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
